// File: rtl/parity_pkg.sv
// Shared types and defaults for the parity stream checker.
package parity_pkg;

    typedef enum logic {
        PAR_EVEN = 1'b0,
        PAR_ODD  = 1'b1
    } par_mode_e;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_IN_FRAME = 1'b1
    } par_state_e;

    localparam int DEF_PAR_WIDTH = 8;

endpackage

// File: rtl/parity_tree.sv
// Combinational XOR reduction of a WIDTH-bit word (even-parity bit of the word).
module parity_tree #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] in_i,
    output logic             out_o
);

    assign out_o = ^in_i;

endmodule

// File: rtl/parity_stream_checker.sv
// Streaming parity checker/generator with frame-level sticky error and one output register stage.
// Define PARITY_ERR_CNT_EN to build the saturating word-error counter.
module parity_stream_checker
    import parity_pkg::*;
#(
    parameter int WIDTH = DEF_PAR_WIDTH,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             mode_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    input  logic [WIDTH-1:0] s_data_i,
    input  logic             s_par_i,
    input  logic             s_last_i,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [WIDTH-1:0] m_data_o,
    output logic             m_par_o,
    output logic             m_par_err_o,
    output logic             m_last_o,
    output logic             m_frame_err_o,
    output logic [CNT_W-1:0] err_cnt_o,
    input  logic             clr_cnt_i
);

    par_state_e       state_q;
    par_mode_e        mode_q;
    par_mode_e        frame_mode;
    logic             frame_acc_q;
    logic             m_valid_q;
    logic [WIDTH-1:0] m_data_q;
    logic             m_par_q;
    logic             m_par_err_q;
    logic             m_last_q;
    logic             m_frame_err_q;
    logic             data_par;
    logic             gen_par;
    logic             word_err;
    logic             accept;

    parity_tree #(
        .WIDTH(WIDTH)
    ) u_tree (
        .in_i (s_data_i),
        .out_o(data_par)
    );

    // The first word of a frame uses the live mode; later words use the held one.
    assign frame_mode = (state_q == ST_IDLE) ? par_mode_e'(mode_i) : mode_q;
    assign gen_par    = data_par ^ frame_mode;
    assign word_err   = (s_par_i != gen_par);
    assign s_ready_o  = !m_valid_q || m_ready_i;
    assign accept     = s_valid_i && s_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            mode_q        <= PAR_EVEN;
            frame_acc_q   <= 1'b0;
            m_valid_q     <= 1'b0;
            m_data_q      <= '0;
            m_par_q       <= 1'b0;
            m_par_err_q   <= 1'b0;
            m_last_q      <= 1'b0;
            m_frame_err_q <= 1'b0;
        end else begin
            if (accept) begin
                m_valid_q     <= 1'b1;
                m_data_q      <= s_data_i;
                m_par_q       <= gen_par;
                m_par_err_q   <= word_err;
                m_last_q      <= s_last_i;
                m_frame_err_q <= s_last_i && (frame_acc_q || word_err);
            end else if (m_ready_i) begin
                m_valid_q <= 1'b0;
            end

            if (accept) begin
                case (state_q)
                    ST_IDLE: begin
                        mode_q <= par_mode_e'(mode_i);
                        if (!s_last_i) begin
                            state_q     <= ST_IN_FRAME;
                            frame_acc_q <= word_err;
                        end
                    end
                    ST_IN_FRAME: begin
                        if (s_last_i) begin
                            state_q     <= ST_IDLE;
                            frame_acc_q <= 1'b0;
                        end else begin
                            frame_acc_q <= frame_acc_q || word_err;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign m_valid_o     = m_valid_q;
    assign m_data_o      = m_data_q;
    assign m_par_o       = m_par_q;
    assign m_par_err_o   = m_par_err_q;
    assign m_last_o      = m_last_q;
    assign m_frame_err_o = m_frame_err_q;

`ifdef PARITY_ERR_CNT_EN
    logic [CNT_W-1:0] err_cnt_q;
    logic [CNT_W-1:0] err_cnt_d;

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clr_cnt_i) begin
            err_cnt_d = '0;
        end else if (accept && word_err && !(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt_o = err_cnt_q;
`else
    logic unused_clr_cnt;
    assign unused_clr_cnt = clr_cnt_i;
    assign err_cnt_o      = '0;
`endif

endmodule

// File: tb/tb_parity_stream_checker.sv
// Self-checking bench for parity_stream_checker: directed cases plus randomized traffic vs. a frame-level model.
module tb_parity_stream_checker;

    localparam int W  = 8;
    localparam int CW = 2;
`ifdef PARITY_ERR_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          mode = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [W-1:0]  s_data = '0;
    logic          s_par = 1'b0;
    logic          s_last = 1'b0;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [W-1:0]  m_data;
    logic          m_par;
    logic          m_par_err;
    logic          m_last;
    logic          m_frame_err;
    logic [CW-1:0] err_cnt;
    logic          clr_cnt = 1'b0;

    always #5 clk = ~clk;

    parity_stream_checker #(
        .WIDTH(W),
        .CNT_W(CW)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .mode_i       (mode),
        .s_valid_i    (s_valid),
        .s_ready_o    (s_ready),
        .s_data_i     (s_data),
        .s_par_i      (s_par),
        .s_last_i     (s_last),
        .m_valid_o    (m_valid),
        .m_ready_i    (m_ready),
        .m_data_o     (m_data),
        .m_par_o      (m_par),
        .m_par_err_o  (m_par_err),
        .m_last_o     (m_last),
        .m_frame_err_o(m_frame_err),
        .err_cnt_o    (err_cnt),
        .clr_cnt_i    (clr_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [W-1:0] d;
        logic         par;
        logic         err;
        logic         last;
        logic         ferr;
    } exp_t;

    exp_t q[$];
    bit   in_frame;
    bit   fmode;
    bit   facc;
    int   cnt;
    bit   md;
    exp_t e;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            in_frame = 0;
            fmode    = 0;
            facc     = 0;
            cnt      = 0;
        end else begin
            if (q.size() > 0 && m_ready) q.pop_front();
            if (s_valid && (q.size() == 0 || m_ready)) begin
                md     = in_frame ? fmode : mode;
                e.d    = s_data;
                e.par  = logic'($countones(s_data) % 2) ^ md;
                e.err  = (s_par != e.par);
                e.last = s_last;
                e.ferr = facc | e.err;
                if (!in_frame) fmode = mode;
                if (s_last) begin
                    in_frame = 0;
                    facc     = 0;
                end else begin
                    in_frame = 1;
                    facc     = e.ferr;
                end
                if (e.err && cnt < (1 << CW) - 1) cnt++;
                q.push_back(e);
            end
            if (clr_cnt) cnt = 0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_valid", m_valid, q.size() > 0);
            chk("s_ready", s_ready, (q.size() == 0) || m_ready);
            if (q.size() > 0) begin
                chk("m_data", m_data, q[0].d);
                chk("m_par", m_par, q[0].par);
                chk("m_par_err", m_par_err, q[0].err);
                chk("m_last", m_last, q[0].last);
                if (q[0].last) chk("m_frame_err", m_frame_err, q[0].ferr);
            end
            chk("err_cnt", err_cnt, CNT_ON ? cnt : 0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [W-1:0] d, input logic p, input logic l,
                        input logic md_i, input logic clr);
        s_data  = d;
        s_par   = p;
        s_last  = l;
        mode    = md_i;
        clr_cnt = clr;
        s_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (s_ready) begin
                @(posedge clk);
                #1;
                s_valid = 1'b0;
                clr_cnt = 1'b0;
                return;
            end
        end
        n_checks++;
        $display("FAIL send_timeout: got s_ready=0 for 50 cycles required acceptance");
        s_valid = 1'b0;
        clr_cnt = 1'b0;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_m_data", m_data, 0);
        chk("rst_err_cnt", err_cnt, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: even single-word frame
        send(8'hA5, 0, 1, 0, 0);
        chk("t1_m_valid", m_valid, 1);
        chk("t1_m_data", m_data, 8'hA5);
        chk("t1_m_par", m_par, 0);
        chk("t1_m_par_err", m_par_err, 0);
        chk("t1_m_frame_err", m_frame_err, 0);

        // 2: odd mode, bad parity
        send(8'h01, 1, 1, 1, 0);
        chk("t2_m_par", m_par, 0);
        chk("t2_m_par_err", m_par_err, 1);
        chk("t2_err_cnt", err_cnt, CNT_ON ? 1 : 0);

        // 3: three-word even frame with a bad middle word
        send(8'h03, 0, 0, 0, 0);
        chk("t3_w0_err", m_par_err, 0);
        send(8'h07, 0, 0, 0, 0);
        chk("t3_w1_err", m_par_err, 1);
        send(8'hFF, 0, 1, 0, 0);
        chk("t3_w2_err", m_par_err, 0);
        chk("t3_frame_err", m_frame_err, 1);
        send(8'h03, 0, 1, 0, 0);
        chk("t3_next_frame_err", m_frame_err, 0);

        // 4: mode toggle inside a frame is ignored until the next frame
        send(8'h03, 0, 0, 0, 0);
        send(8'h01, 1, 0, 1, 0);
        chk("t4_w1_par", m_par, 1);
        chk("t4_w1_err", m_par_err, 0);
        send(8'h01, 1, 1, 1, 0);
        chk("t4_w2_frame_err", m_frame_err, 0);
        send(8'h01, 0, 1, 1, 0);
        chk("t4_next_par", m_par, 0);
        chk("t4_next_err", m_par_err, 0);

        // 5: backpressure for 4 cycles
        @(posedge clk); #1;
        m_ready = 1'b0;
        send(8'h5A, 0, 1, 0, 0);
        s_data = 8'hC3; s_par = 0; s_last = 1; mode = 0; s_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("t5_s_ready", s_ready, 0);
            chk("t5_hold_data", m_data, 8'h5A);
        end
        m_ready = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0;
        chk("t5_next_data", m_data, 8'hC3);
        @(posedge clk); #1;
        chk("t5_drain", m_valid, 0);

        // 6: counter saturation and clear priority
        send(8'h00, 0, 1, 0, 1);
        chk("t6_clr", err_cnt, 0);
        for (int k = 1; k <= 5; k++) begin
            send(8'h00, 1, 1, 0, 0);
            chk("t6_sat", err_cnt, CNT_ON ? ((k < 3) ? k : 3) : 0);
        end
        send(8'h00, 1, 1, 0, 1);
        chk("t6_clr_prio", err_cnt, 0);

        // 7: reset mid-frame after an erroneous word
        send(8'h07, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_m_valid", m_valid, 0);
        chk("t7_m_data", m_data, 0);
        chk("t7_m_par_err", m_par_err, 0);
        chk("t7_err_cnt", err_cnt, 0);
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        send(8'h03, 0, 1, 0, 0);
        chk("t7_last", m_last, 1);
        chk("t7_frame_err", m_frame_err, 0);

        // randomized traffic
        for (int c = 0; c < 800; c++) begin
            s_valid = ($urandom_range(0, 9) < 7);
            s_data  = W'($urandom);
            s_par   = 1'($urandom);
            s_last  = ($urandom_range(0, 3) == 0);
            mode    = 1'($urandom);
            clr_cnt = ($urandom_range(0, 40) == 0);
            m_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        clr_cnt = 1'b0;
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
